// File: rtl/stack_ctrl_param_if.sv
// stack_ctrl_param_if: signal bundle between the stack CPU controller and its datapath/memory
interface stack_ctrl_param_if #(
  parameter int IW  = 16,
  parameter int NLD = 9,
  parameter int NTR = 6
);
  logic           MFC;
  logic           Status;
  logic           Halt;
  logic [IW-1:0]  Instruction;
  logic           DataReset;
  logic [NLD-1:0] LoadSignal;
  logic [NTR-1:0] TransferSignal;
  logic [2:0]     ALOP;
  logic           RD;
  logic           WR;
  logic           Retire;
  logic           Fault;
  logic           Halted;
  modport master (
    input  MFC, Status, Halt, Instruction,
    output DataReset, LoadSignal, TransferSignal, ALOP, RD, WR, Retire, Fault, Halted
  );
  modport slave (
    output MFC, Status, Halt, Instruction,
    input  DataReset, LoadSignal, TransferSignal, ALOP, RD, WR, Retire, Fault, Halted
  );
endinterface

// File: rtl/stack_ctrl_param.sv
// stack_ctrl_param: phase/state sequencer for the stack CPU with MFC timeout, retire pulse and halt
module stack_ctrl_param #(
  parameter int IW          = 16,
  parameter int NLD         = 9,
  parameter int NTR         = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  stack_ctrl_param_if.master bus
);
  typedef enum logic [3:0] {
    P_RESET, P_FETCH, P_PUSH, P_POP, P_BRANCH, P_CALL, P_RETURN, P_POSTEX, P_HALT, P_FAULT
  } phase_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam int L_R = 0, L_PC = 1, L_SP = 2, L_F = 3, L_T = 4, L_MAR = 5, L_MDM = 6, L_MDZ = 7, L_IR = 8;
  localparam int T_R = 0, T_PC = 1, T_SP = 2, T_MDR = 4, T_L = 5;
  localparam logic [2:0] A_CPY = 3'd0, A_ADD = 3'd1, A_NOTY = 3'd4, A_CPX = 3'd5, A_INX = 3'd6, A_DCX = 3'd7;
  phase_t        phase_q, phase_d;
  logic [2:0]    state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d, fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op, sub;
  logic [2:0]    last, alop;
  logic [8:0]    ld;
  logic [5:0]    tr;
  logic          waiting, timeout, rd_go, wr_go, taken;
  assign op      = bus.Instruction[IW-1:IW-4];
  assign sub     = bus.Instruction[IW-5:IW-8];
  assign taken   = op[3:1] == 3'b000 || bus.Status;
  assign waiting = (state_q == 3'd1 && (phase_q == P_FETCH || phase_q == P_POP || phase_q == P_RETURN))
                || (phase_q == P_PUSH && state_q == 3'd2) || (phase_q == P_CALL && state_q == 3'd3);
  assign timeout = waiting && !bus.MFC && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign rd_go   = state_q == 3'd0 && (phase_q == P_FETCH || phase_q == P_POP || phase_q == P_RETURN);
  assign wr_go   = (phase_q == P_PUSH && state_q == 3'd1) || (phase_q == P_CALL && state_q == 3'd2);
  // Final state index of each phase; single-cycle phases (PostEx/Halt/Fault) end at 0
  assign last = (phase_q == P_RESET || phase_q == P_BRANCH) ? 3'd1
              : (phase_q == P_FETCH || phase_q == P_RETURN) ? 3'd2
              : (phase_q == P_PUSH || phase_q == P_POP) ? 3'd3
              : phase_q == P_CALL ? 3'd5 : 3'd0;
  // State register; the memory handshake and fault flag are registered alongside phase/state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= P_RESET;
      state_q <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
  // Next phase/state: wait states hold until MFC, the last state of a phase picks the successor, timeout overrides all
  always_comb begin
    state_d = state_q == last ? 3'd0 : (waiting && !bus.MFC) ? state_q : state_q + 3'd1;
    phase_d = state_q != last ? phase_q
            : phase_q == P_RESET ? P_FETCH
            : phase_q == P_FETCH ? (op == 4'd0 ? (sub != 4'd0 ? P_POP : P_PUSH)
                                   : op[3:1] == 3'b111 ? (op[0] ? P_RETURN : P_CALL) : P_BRANCH)
            : phase_q == P_POSTEX ? (bus.Halt ? P_HALT : P_FETCH)
            : phase_q == P_HALT ? (bus.Halt ? P_HALT : P_FETCH)
            : phase_q == P_FAULT ? P_FAULT : P_POSTEX;
    rd_d    = rd_go || (rd_q && !(waiting && bus.MFC));
    wr_d    = wr_go || (wr_q && !(waiting && bus.MFC));
    cnt_d   = (rd_go || wr_go) ? '0 : waiting ? cnt_q + CW'(1) : cnt_q;
    fault_d = fault_q || timeout;
    if (timeout) begin
      phase_d = P_FAULT;
      state_d = 3'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end
  end
  // Strobe decode from phase/state; anything not named stays 0 and the ALU defaults to CPY
  always_comb begin
    ld   = '0;
    tr   = '0;
    alop = A_CPY;
    unique case ({phase_q, state_q})
      {P_RESET,  3'd1}: begin alop = A_NOTY; ld[L_SP] = 1'b1; end
      {P_FETCH,  3'd0}: begin alop = A_CPX; tr[T_PC] = 1'b1; ld[L_MAR] = 1'b1; end
      {P_FETCH,  3'd1}: ld[L_IR] = 1'b1;
      {P_FETCH,  3'd2}: begin alop = A_INX; tr[T_PC] = 1'b1; ld[L_PC] = 1'b1; end
      {P_PUSH,   3'd0}: begin alop = A_CPX; tr[T_SP] = 1'b1; ld[L_MAR] = 1'b1; end
      {P_PUSH,   3'd1}: begin alop = A_CPX; tr[T_R] = 1'b1; ld[L_MDZ] = 1'b1; end
      {P_PUSH,   3'd3}: begin alop = A_DCX; tr[T_SP] = 1'b1; ld[L_SP] = 1'b1; end
      {P_POP,    3'd0}: begin alop = A_INX; tr[T_SP] = 1'b1; ld[L_SP] = 1'b1; ld[L_MAR] = 1'b1; end
      {P_POP,    3'd1}: ld[L_MDM] = 1'b1;
      {P_POP,    3'd2}: begin tr[T_MDR] = 1'b1; ld[L_T] = 1'b1; end
      {P_POP,    3'd3}: begin alop = sub[2:0]; tr[T_R] = 1'b1; ld[L_R] = 1'b1; ld[L_F] = 1'b1; end
      {P_BRANCH, 3'd0}: begin tr[T_L] = 1'b1; ld[L_T] = 1'b1; end
      {P_BRANCH, 3'd1}: begin alop = A_ADD; tr[T_PC] = taken; ld[L_PC] = taken; end
      {P_CALL,   3'd0}: begin alop = A_CPX; tr[T_PC] = 1'b1; ld[L_MDZ] = 1'b1; end
      {P_CALL,   3'd1}: begin alop = A_CPX; tr[T_SP] = 1'b1; ld[L_MAR] = 1'b1; end
      {P_CALL,   3'd2}: begin alop = A_DCX; tr[T_SP] = 1'b1; ld[L_SP] = 1'b1; end
      {P_CALL,   3'd4}: begin tr[T_L] = 1'b1; ld[L_T] = 1'b1; end
      {P_CALL,   3'd5}: begin alop = A_ADD; tr[T_PC] = 1'b1; ld[L_PC] = 1'b1; end
      {P_RETURN, 3'd0}: begin alop = A_INX; tr[T_SP] = 1'b1; ld[L_SP] = 1'b1; ld[L_MAR] = 1'b1; end
      {P_RETURN, 3'd1}: ld[L_MDM] = 1'b1;
      {P_RETURN, 3'd2}: begin alop = A_CPX; tr[T_MDR] = 1'b1; ld[L_PC] = 1'b1; end
      default: ;
    endcase
  end
  assign bus.DataReset      = phase_q == P_RESET && state_q == 3'd0;
  assign bus.LoadSignal     = NLD'(ld);
  assign bus.TransferSignal = NTR'(tr);
  assign bus.ALOP           = alop;
  assign bus.RD             = rd_q;
  assign bus.WR             = wr_q;
  assign bus.Retire         = phase_q == P_POSTEX;
  assign bus.Fault          = fault_q;
  assign bus.Halted         = phase_q == P_HALT;
endmodule

// File: tb/tb_stack_ctrl_param.sv
// tb_stack_ctrl_param: table-driven instruction sequences checked cycle by cycle against a scoreboard queue
module tb_stack_ctrl_param;
  localparam logic [8:0] LR = 9'h001, LPC = 9'h002, LSP = 9'h004, LF = 9'h008, LT = 9'h010,
                         LMAR = 9'h020, LMDM = 9'h040, LMDZ = 9'h080, LIR = 9'h100;
  localparam logic [5:0] TR = 6'h01, TPC = 6'h02, TSP = 6'h04, TMDR = 6'h10, TL = 6'h20;
  localparam logic [2:0] CPY = 3'd0, ADD = 3'd1, NOTY = 3'd4, CPX = 3'd5, INX = 3'd6, DCX = 3'd7;
  typedef struct {
    string       nm;
    logic [25:0] v;
  } rec_t;
  typedef struct {
    logic [15:0] ins;
    logic        st;
    logic        mfc_all;
    int          dly;
    int          lat;
  } vec_t;
  logic clk, reset;
  int   checks, errors, wc, mfc_dly;
  logic mfc_all;
  rec_t q[$];
  vec_t vecs[13];
  stack_ctrl_param_if #(.IW(16), .NLD(10), .NTR(7)) bus();
  stack_ctrl_param #(.IW(16), .NLD(10), .NTR(7), .MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [25:0] pk(logic dr, logic [8:0] ld, logic [5:0] tr, logic [2:0] al,
                                     logic rd, logic wr, logic ret, logic flt, logic hlt);
    return {dr, 1'b0, ld, 1'b0, tr, al, rd, wr, ret, flt, hlt};
  endfunction
  function automatic void e(string nm, logic [8:0] ld, logic [5:0] tr, logic [2:0] al,
                            logic rd = 1'b0, logic wr = 1'b0);
    q.push_back('{nm, pk(1'b0, ld, tr, al, rd, wr, 1'b0, 1'b0, 1'b0)});
  endfunction
  function automatic void exp_fetch(int nw);
    e("F0", LMAR, TPC, CPX);
    for (int i = 0; i < nw; i++) e("F1", LIR, 0, CPY, 1'b1);
    e("F2", LPC, TPC, INX);
  endfunction
  function automatic void exp_instr(logic [15:0] ins, logic st, int nw);
    logic [3:0] op, sb;
    logic tk;
    op = ins[15:12];
    sb = ins[11:8];
    tk = (op == 4'd1) || st;
    exp_fetch(nw);
    if (op == 4'd0 && sb != 4'd0) begin
      e("POP0", LSP | LMAR, TSP, INX);
      for (int i = 0; i < nw; i++) e("POP1", LMDM, 0, CPY, 1'b1);
      e("POP2", LT, TMDR, CPY);
      e("POP3", LR | LF, TR, sb[2:0]);
    end else if (op == 4'd0) begin
      e("PUSH0", LMAR, TSP, CPX);
      e("PUSH1", LMDZ, TR, CPX);
      for (int i = 0; i < nw; i++) e("PUSH2", 0, 0, CPY, 1'b0, 1'b1);
      e("PUSH3", LSP, TSP, DCX);
    end else if (op == 4'hE) begin
      e("CALL0", LMDZ, TPC, CPX);
      e("CALL1", LMAR, TSP, CPX);
      e("CALL2", LSP, TSP, DCX);
      for (int i = 0; i < nw; i++) e("CALL3", 0, 0, CPY, 1'b0, 1'b1);
      e("CALL4", LT, TL, CPY);
      e("CALL5", LPC, TPC, ADD);
    end else if (op == 4'hF) begin
      e("RET0", LSP | LMAR, TSP, INX);
      for (int i = 0; i < nw; i++) e("RET1", LMDM, 0, CPY, 1'b1);
      e("RET2", LPC, TMDR, CPX);
    end else begin
      e("BR0", LT, TL, CPY);
      e("BR1", tk ? LPC : 9'h000, tk ? TPC : 6'h00, ADD);
    end
    q.push_back('{"POSTEX", pk(1'b0, 0, 0, CPY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
  endfunction
  task automatic chk(input rec_t r);
    logic [25:0] a;
    a = {bus.DataReset, bus.LoadSignal, bus.TransferSignal, bus.ALOP,
         bus.RD, bus.WR, bus.Retire, bus.Fault, bus.Halted};
    checks++;
    if (a !== r.v) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", r.nm, a, r.v, $time);
    end
  endtask
  task automatic run_queue(input int lat);
    int n = 0;
    rec_t r;
    while (q.size() != 0 && n < 500) begin
      wc = (bus.RD || bus.WR) ? wc + 1 : 0;
      bus.MFC = mfc_all || ((bus.RD || bus.WR) && wc > mfc_dly);
      r = q.pop_front();
      chk(r);
      if (lat >= 0 && bus.Retire) begin
        checks++;
        if (n != lat - 1) begin
          errors++;
          $display("FAIL latency got %0d want %0d", n + 1, lat);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL cycle_budget %0d records left", q.size());
      q.delete();
    end
  endtask
  task automatic do_reset();
    bus.MFC = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk('{"RST_HELD", pk(1'b1, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    reset = 1'b0;
    q.push_back('{"RST_S0", pk(1'b1, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    e("RST_S1", LSP, 0, NOTY);
    run_queue(-1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    checks = 0;
    errors = 0;
    wc = 0;
    mfc_dly = 0;
    mfc_all = 1'b0;
    bus.MFC = 1'b0;
    bus.Status = 1'b0;
    bus.Halt = 1'b0;
    bus.Instruction = 16'h0000;
    vecs = '{
      '{16'h0000, 1'b0, 1'b0, 0, 8},
      '{16'h0300, 1'b0, 1'b0, 0, 8},
      '{16'h0800, 1'b0, 1'b0, 0, 8},
      '{16'h0D00, 1'b0, 1'b0, 0, 8},
      '{16'h2000, 1'b0, 1'b0, 0, 6},
      '{16'h2000, 1'b1, 1'b0, 0, 6},
      '{16'h1234, 1'b0, 1'b0, 0, 6},
      '{16'hC0FF, 1'b0, 1'b0, 0, 6},
      '{16'hE000, 1'b0, 1'b0, 0, 10},
      '{16'hF000, 1'b0, 1'b0, 0, 7},
      '{16'h0000, 1'b0, 1'b1, 0, 8},
      '{16'hE000, 1'b0, 1'b0, 3, 16},
      '{16'h0000, 1'b0, 1'b0, 3, 14}
    };
    do_reset();
    foreach (vecs[i]) begin
      bus.Instruction = vecs[i].ins;
      bus.Status = vecs[i].st;
      mfc_all = vecs[i].mfc_all;
      mfc_dly = vecs[i].dly;
      exp_instr(vecs[i].ins, vecs[i].st, mfc_all ? 1 : vecs[i].dly + 1);
      run_queue(vecs[i].lat);
    end
    mfc_all = 1'b0;
    mfc_dly = 99;
    e("F0", LMAR, TPC, CPX);
    for (int i = 0; i < 4; i++) e("F1_WAIT", LIR, 0, CPY, 1'b1);
    for (int i = 0; i < 5; i++)
      q.push_back('{"FAULT", pk(1'b0, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)});
    run_queue(-1);
    mfc_dly = 0;
    do_reset();
    bus.Halt = 1'b1;
    bus.Instruction = 16'h0300;
    exp_instr(16'h0300, 1'b0, 1);
    for (int i = 0; i < 3; i++)
      q.push_back('{"HALTED", pk(1'b0, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    run_queue(8);
    bus.Halt = 1'b0;
    bus.Instruction = 16'h2000;
    bus.Status = 1'b1;
    q.push_back('{"HALT_LAST", pk(1'b0, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    exp_instr(16'h2000, 1'b1, 1);
    run_queue(-1);
    bus.Instruction = 16'hE000;
    exp_fetch(1);
    e("CALL0", LMDZ, TPC, CPX);
    e("CALL1", LMAR, TSP, CPX);
    e("CALL2", LSP, TSP, DCX);
    run_queue(-1);
    chk('{"CALL3_WR", pk(1'b0, 0, 0, CPY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)});
    reset = 1'b1;
    #1;
    chk('{"RST_ASYNC", pk(1'b1, 0, 0, CPY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
